// File: rtl/sawtooth_wave_gen.sv
// Programmable sawtooth/triangle generator: bounds are loaded serially through v_i/din_i,
// then the counter steps between them once per prescaler tick in the selected mode.
module sawtooth_wave_gen #(
    parameter int unsigned W        = 8,
    parameter int unsigned STEP_W   = 4,
    parameter int unsigned TICK_DIV = 12500000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              v_i,
    input  logic [W-1:0]      din_i,
    input  logic [1:0]        mode_i,
    input  logic [STEP_W-1:0] step_i,
    output logic              tick_o,
    output logic [1:0]        state_o,
    output logic [W-1:0]      n1_o,
    output logic [W-1:0]      n2_o,
    output logic [W-1:0]      cnt_o,
    output logic              dir_o,
    output logic              wrap_o
);

    localparam int unsigned PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW    = W + 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD_N1 = 2'b01,
        LOAD_N2 = 2'b10,
        RUN     = 2'b11
    } state_t;

    state_t           state_q, state_nxt;
    logic [W-1:0]     tmp_q, tmp_nxt;
    logic [W-1:0]     n1_nxt, n2_nxt, cnt_nxt;
    logic             dir_nxt, wrap_nxt;
    logic             v_q, v_rise;
    logic [PSC_W-1:0] psc_q, psc_nxt;

    // Widened operands so bound comparisons cannot overflow at 2^W-1.
    logic [SW-1:0]    s, cnt_w, hi_w, cnt_up, lo_s;

    assign v_rise  = v_i & ~v_q;
    assign psc_nxt = (psc_q == PSC_LAST) ? '0 : psc_q + PSC_W'(1);
    assign state_o = state_q;

    assign s      = (step_i == '0) ? SW'(1) : SW'(step_i);
    assign cnt_w  = SW'(cnt_o);
    assign hi_w   = SW'(n2_o);
    assign cnt_up = cnt_w + s;
    assign lo_s   = SW'(n1_o) + s;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tmp_q   <= '0;
            n1_o    <= '0;
            n2_o    <= '0;
            cnt_o   <= '0;
            dir_o   <= 1'b0;
            wrap_o  <= 1'b0;
            psc_q   <= '0;
            tick_o  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            tmp_q   <= tmp_nxt;
            n1_o    <= n1_nxt;
            n2_o    <= n2_nxt;
            cnt_o   <= cnt_nxt;
            dir_o   <= dir_nxt;
            wrap_o  <= wrap_nxt;
            psc_q   <= psc_nxt;
            tick_o  <= (psc_nxt == PSC_LAST);
            v_q     <= v_i;
        end
    end

    // Next-state and datapath update; a button edge in RUN pre-empts the tick step
    always_comb begin
        state_nxt = state_q;
        tmp_nxt   = tmp_q;
        n1_nxt    = n1_o;
        n2_nxt    = n2_o;
        cnt_nxt   = cnt_o;
        dir_nxt   = dir_o;
        wrap_nxt  = 1'b0;

        case (state_q)
            IDLE: begin
                if (v_rise) state_nxt = LOAD_N1;
            end
            LOAD_N1: begin
                if (v_rise) begin
                    tmp_nxt   = din_i;
                    state_nxt = LOAD_N2;
                end
            end
            LOAD_N2: begin
                if (v_rise) begin
                    n1_nxt    = (tmp_q < din_i) ? tmp_q : din_i;
                    n2_nxt    = (tmp_q < din_i) ? din_i : tmp_q;
                    cnt_nxt   = (mode_i == MODE_DOWN) ? n2_nxt : n1_nxt;
                    dir_nxt   = (mode_i == MODE_DOWN);
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (v_rise) begin
                    state_nxt = LOAD_N1;
                end else if (tick_o && (n1_o != n2_o)) begin
                    case (mode_i)
                        MODE_UP: begin
                            dir_nxt = 1'b0;
                            if (cnt_up > hi_w) begin
                                cnt_nxt  = n1_o;
                                wrap_nxt = 1'b1;
                            end else begin
                                cnt_nxt = W'(cnt_up);
                            end
                        end
                        MODE_DOWN: begin
                            dir_nxt = 1'b1;
                            if (cnt_w < lo_s) begin
                                cnt_nxt  = n2_o;
                                wrap_nxt = 1'b1;
                            end else begin
                                cnt_nxt = W'(cnt_w - s);
                            end
                        end
                        MODE_TRI: begin
                            if (!dir_o) begin
                                if (cnt_up >= hi_w) begin
                                    cnt_nxt  = n2_o;
                                    dir_nxt  = 1'b1;
                                    wrap_nxt = 1'b1;
                                end else begin
                                    cnt_nxt = W'(cnt_up);
                                end
                            end else begin
                                if (cnt_w <= lo_s) begin
                                    cnt_nxt  = n1_o;
                                    dir_nxt  = 1'b0;
                                    wrap_nxt = 1'b1;
                                end else begin
                                    cnt_nxt = W'(cnt_w - s);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sawtooth_wave_gen.sv
// Directed bench for sawtooth_wave_gen with a 4-cycle prescaler: bound loading,
// the three stepping modes, hold, full-range boundary, equal bounds and reset.
module tb_sawtooth_wave_gen;

    localparam int unsigned W        = 8;
    localparam int unsigned STEP_W   = 4;
    localparam int unsigned TICK_DIV = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              v;
    logic [W-1:0]      din;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic              tick_o;
    logic [1:0]        state_o;
    logic [W-1:0]      n1_o, n2_o, cnt_o;
    logic              dir_o, wrap_o;

    int checks = 0;
    int errors = 0;

    int tri_cnt  [7] = '{14, 18, 20, 16, 12, 10, 14};
    int tri_dir  [7] = '{0, 0, 1, 1, 1, 0, 0};
    int tri_wrap [7] = '{0, 0, 1, 0, 0, 1, 0};

    sawtooth_wave_gen #(.W(W), .STEP_W(STEP_W), .TICK_DIV(TICK_DIV)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .v_i     (v),
        .din_i   (din),
        .mode_i  (mode),
        .step_i  (step),
        .tick_o  (tick_o),
        .state_o (state_o),
        .n1_o    (n1_o),
        .n2_o    (n2_o),
        .cnt_o   (cnt_o),
        .dir_o   (dir_o),
        .wrap_o  (wrap_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle so the edge detector sees a low level, then a one-cycle press.
    task automatic press(input logic [W-1:0] d);
        cyc();
        din = d;
        v   = 1'b1;
        cyc();
        v   = 1'b0;
    endtask

    // Advance to just after the edge that closes the next tick cycle.
    task automatic step_tick();
        int n;
        n = 0;
        while (tick_o !== 1'b1 && n < 16) begin
            cyc();
            n++;
        end
        if (tick_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout got tick_o=%b after %0d cycles exp 1", tick_o, n);
        end
        cyc();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        v    = 1'b0;
        din  = '0;
        mode = 2'b00;
        step = '0;
        repeat (3) cyc();
        checks++;
        if (state_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_state got %0d exp 0", state_o);
        end
        checks++;
        if ({n1_o, n2_o, cnt_o, dir_o, tick_o, wrap_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got n1=%0d n2=%0d cnt=%0d dir=%b tick=%b wrap=%b exp all 0",
                     n1_o, n2_o, cnt_o, dir_o, tick_o, wrap_o);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            checks++;
            if (tick_o !== ((k == 3) || (k == 7))) begin
                errors++;
                $display("FAIL tick_cycle_%0d got %b exp %b", k, tick_o, ((k == 3) || (k == 7)));
            end
        end
    endtask

    task automatic test_up_saw();
        press(8'd0);
        checks++;
        if (state_o !== 2'b01) begin
            errors++;
            $display("FAIL up_state_load_n1 got %0d exp 1", state_o);
        end
        press(8'd20);
        checks++;
        if (state_o !== 2'b10) begin
            errors++;
            $display("FAIL up_state_load_n2 got %0d exp 2", state_o);
        end
        mode = 2'b00;
        step = 4'd1;
        press(8'd40);
        checks++;
        if (state_o !== 2'b11 || n1_o !== 8'd20 || n2_o !== 8'd40 || cnt_o !== 8'd20 || dir_o !== 1'b0) begin
            errors++;
            $display("FAIL up_entry got st=%0d n1=%0d n2=%0d cnt=%0d dir=%b exp 3 20 40 20 0",
                     state_o, n1_o, n2_o, cnt_o, dir_o);
        end
        for (int i = 1; i <= 20; i++) begin
            step_tick();
            checks++;
            if (cnt_o !== W'(20 + i) || wrap_o !== 1'b0) begin
                errors++;
                $display("FAIL up_step_%0d got cnt=%0d wrap=%b exp %0d 0", i, cnt_o, wrap_o, 20 + i);
            end
        end
        step_tick();
        checks++;
        if (cnt_o !== 8'd20 || wrap_o !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap got cnt=%0d wrap=%b exp 20 1", cnt_o, wrap_o);
        end
        cyc();
        checks++;
        if (wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap_pulse got wrap=%b exp 0", wrap_o);
        end
    endtask

    task automatic test_down_saw();
        press(8'd99);
        checks++;
        if (state_o !== 2'b01 || cnt_o !== 8'd20) begin
            errors++;
            $display("FAIL down_leave_run got st=%0d cnt=%0d exp 1 20", state_o, cnt_o);
        end
        press(8'd76);
        mode = 2'b01;
        step = 4'd5;
        press(8'd15);
        checks++;
        if (state_o !== 2'b11 || n1_o !== 8'd15 || n2_o !== 8'd76 || cnt_o !== 8'd76 || dir_o !== 1'b1) begin
            errors++;
            $display("FAIL down_entry got st=%0d n1=%0d n2=%0d cnt=%0d dir=%b exp 3 15 76 76 1",
                     state_o, n1_o, n2_o, cnt_o, dir_o);
        end
        for (int i = 1; i <= 12; i++) begin
            step_tick();
            checks++;
            if (cnt_o !== W'(76 - 5 * i) || wrap_o !== 1'b0 || dir_o !== 1'b1) begin
                errors++;
                $display("FAIL down_step_%0d got cnt=%0d wrap=%b dir=%b exp %0d 0 1",
                         i, cnt_o, wrap_o, dir_o, 76 - 5 * i);
            end
        end
        step_tick();
        checks++;
        if (cnt_o !== 8'd76 || wrap_o !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap got cnt=%0d wrap=%b exp 76 1", cnt_o, wrap_o);
        end
    endtask

    task automatic test_triangle();
        press(8'd0);
        press(8'd10);
        mode = 2'b10;
        step = 4'd4;
        press(8'd20);
        checks++;
        if (n1_o !== 8'd10 || n2_o !== 8'd20 || cnt_o !== 8'd10 || dir_o !== 1'b0) begin
            errors++;
            $display("FAIL tri_entry got n1=%0d n2=%0d cnt=%0d dir=%b exp 10 20 10 0",
                     n1_o, n2_o, cnt_o, dir_o);
        end
        for (int i = 0; i < 7; i++) begin
            step_tick();
            checks++;
            if (cnt_o !== W'(tri_cnt[i]) || dir_o !== 1'(tri_dir[i]) || wrap_o !== 1'(tri_wrap[i])) begin
                errors++;
                $display("FAIL tri_step_%0d got cnt=%0d dir=%b wrap=%b exp %0d %0d %0d",
                         i, cnt_o, dir_o, wrap_o, tri_cnt[i], tri_dir[i], tri_wrap[i]);
            end
        end
    endtask

    task automatic test_full_range();
        press(8'd0);
        press(8'd0);
        mode = 2'b00;
        step = 4'd15;
        press(8'd255);
        checks++;
        if (n1_o !== 8'd0 || n2_o !== 8'd255 || cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL full_entry got n1=%0d n2=%0d cnt=%0d exp 0 255 0", n1_o, n2_o, cnt_o);
        end
        for (int i = 1; i <= 16; i++) begin
            step_tick();
            checks++;
            if (cnt_o !== W'(15 * i)) begin
                errors++;
                $display("FAIL full_step_%0d got cnt=%0d exp %0d", i, cnt_o, 15 * i);
            end
        end
        step_tick();
        checks++;
        if (cnt_o !== 8'd255 || wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL full_top got cnt=%0d wrap=%b exp 255 0", cnt_o, wrap_o);
        end
        step_tick();
        checks++;
        if (cnt_o !== 8'd0 || wrap_o !== 1'b1) begin
            errors++;
            $display("FAIL full_wrap got cnt=%0d wrap=%b exp 0 1", cnt_o, wrap_o);
        end
        step = 4'd0;
        step_tick();
        checks++;
        if (cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL step_zero got cnt=%0d exp 1", cnt_o);
        end
        mode = 2'b11;
        step = 4'd7;
        for (int i = 0; i < 3; i++) begin
            step_tick();
            checks++;
            if (cnt_o !== 8'd1 || wrap_o !== 1'b0 || dir_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got cnt=%0d wrap=%b dir=%b exp 1 0 0", i, cnt_o, wrap_o, dir_o);
            end
        end
    endtask

    task automatic test_v_during_tick();
        int n;
        mode = 2'b00;
        step = 4'd1;
        n = 0;
        while (tick_o !== 1'b1 && n < 16) begin
            cyc();
            n++;
        end
        checks++;
        if (tick_o !== 1'b1) begin
            errors++;
            $display("FAIL vtick_wait got tick_o=%b exp 1", tick_o);
        end
        v = 1'b1;
        cyc();
        checks++;
        if (state_o !== 2'b01 || cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL vtick_priority got st=%0d cnt=%0d exp 1 1", state_o, cnt_o);
        end
        repeat (3) cyc();
        checks++;
        if (state_o !== 2'b01) begin
            errors++;
            $display("FAIL held_button got st=%0d exp 1", state_o);
        end
        v = 1'b0;
        step_tick();
        step_tick();
        checks++;
        if (cnt_o !== 8'd1 || wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL frozen_outside_run got cnt=%0d wrap=%b exp 1 0", cnt_o, wrap_o);
        end
    endtask

    task automatic test_equal_bounds();
        press(8'd50);
        press(8'd50);
        checks++;
        if (state_o !== 2'b11 || n1_o !== 8'd50 || n2_o !== 8'd50 || cnt_o !== 8'd50) begin
            errors++;
            $display("FAIL eq_entry got st=%0d n1=%0d n2=%0d cnt=%0d exp 3 50 50 50",
                     state_o, n1_o, n2_o, cnt_o);
        end
        for (int m = 0; m < 3; m++) begin
            mode = 2'(m);
            for (int i = 0; i < 2; i++) begin
                step_tick();
                checks++;
                if (cnt_o !== 8'd50 || wrap_o !== 1'b0) begin
                    errors++;
                    $display("FAIL eq_mode%0d_%0d got cnt=%0d wrap=%b exp 50 0", m, i, cnt_o, wrap_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        cyc();
        checks++;
        if (state_o !== 2'b00 || {n1_o, n2_o, cnt_o, dir_o, tick_o, wrap_o} !== '0) begin
            errors++;
            $display("FAIL mid_run_reset got st=%0d n1=%0d n2=%0d cnt=%0d dir=%b tick=%b wrap=%b exp all 0",
                     state_o, n1_o, n2_o, cnt_o, dir_o, tick_o, wrap_o);
        end
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_up_saw();
        test_down_saw();
        test_triangle();
        test_full_range();
        test_v_during_tick();
        test_equal_bounds();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
